i2s_slave_rx: RTL and testbench
===============================

Name: i2s_slave_rx

Overview:
- I2S slave receiver on the codec side of the I2S link.
- Consumes externally generated BCLK, LRCLK and SDATA, and oversamples them in the data clock domain.
- Deserialises each channel word MSB-first and buffers samples in a small FIFO.
- Presents samples on an AXI-Stream style master port, tagged with channel, for loopback test and capture of the PS-side I2S transmitter output.

Parameters:
- SLOT_WIDTH, 24, sample bits delivered per channel word (left-justified, MSB first).
- FIFO_DEPTH, 4, sample FIFO entries; power of two, at least 2.

Ports:
- DATA_CLK_I  in  1  data clock; must be at least 4x BCLK_I frequency.
- RESETN  in  1  asynchronous active-low reset.
- ENABLE_I  in  1  receiver enable; low flushes the FIFO and returns to IDLE.
- BCLK_I  in  1  I2S bit clock, asynchronous to DATA_CLK_I.
- LRCLK_I  in  1  I2S word select; 0 = left, 1 = right.
- SDATA_I  in  1  I2S serial data.
- M_TDATA  out  SLOT_WIDTH  sample at FIFO head.
- M_TID  out  1  channel of M_TDATA; 0 = left, 1 = right.
- M_TVALID  out  1  FIFO non-empty.
- M_TREADY  in  1  downstream accept.
- OVERRUN_O  out  1  sticky: a completed word was dropped because the FIFO was full.

Behaviour:
- One clock (DATA_CLK_I); reset is asynchronous and active-low (RESETN).
- Reset values: M_TDATA=0, M_TID=0, M_TVALID=0, OVERRUN_O=0, FSM=IDLE, FIFO empty, counters 0.
- Synchronisation and edge detection:
  - BCLK_I, LRCLK_I and SDATA_I each pass through a 2-flop synchroniser.
  - A bit event is the DATA_CLK_I cycle in which synchronised BCLK is 1 and its previous value was 0.
  - Latency from pad edge to bit event is 3 DATA_CLK_I cycles.
  - LRCLK and SDATA are sampled together at each bit event.
- Framing (standard I2S, one-bit delay):
  - A word boundary is a bit event whose sampled LR differs from the LR sampled at the previous bit event.
  - The SDATA bit taken at a boundary event is the last bit of the previous word.
  - The following bit event is the MSB of the new word.
- Per-word deserialisation:
  - bit_cnt counts the bits of the current word.
  - Bits with index < SLOT_WIDTH are shifted into the word register MSB first; later bits are ignored.
  - If the word ends with fewer than SLOT_WIDTH bits, the remaining LSBs are 0.
  - bit_cnt saturates at 63.
- Word completion: at a boundary event the word is finalised with channel = previous LR and pushed to the FIFO in the next cycle. The shift register and bit_cnt then clear for the new word.
- FSM states:
  - IDLE: ENABLE_I=0; ignores bit events. Goes to SYNC when ENABLE_I=1.
  - SYNC: waits for the first boundary event. The partial word before it is discarded (no push). Goes to RUN at that event.
  - RUN: at every boundary event, pushes the completed word.
  - Any state goes to IDLE in the cycle after ENABLE_I=0. In that cycle the FIFO is flushed, M_TVALID drops, and any in-progress word is discarded.
- FIFO and output handshake:
  - A pop occurs when M_TVALID & M_TREADY.
  - M_TDATA/M_TID are stable while M_TVALID=1 and M_TREADY=0.
  - Output ordering is strictly first in, first out.
- FIFO boundary conditions:
  - Push when full with no pop: the new word is dropped, FIFO contents are unchanged, and OVERRUN_O sets.
  - Push and pop in the same cycle when full: the pop is honoured, the push succeeds, and there is no overrun.
  - Push and pop in the same cycle when empty is impossible: a push becomes visible on M_TVALID one cycle after the push cycle.
- OVERRUN_O: cleared only by reset or by ENABLE_I=0.
- Asserting RESETN mid-frame clears all state immediately, with no waiting for a clock edge.

Decomposition:
- Package i2s_pkg:
  - FSM state enum (IDLE, SYNC, RUN).
  - CH_LEFT=0, CH_RIGHT=1.
  - Bit-counter width constant (6).
- Sub-module i2s_sample_fifo:
  - Synchronous FIFO, width SLOT_WIDTH+1, depth FIFO_DEPTH.
  - Provides full/empty flags and the flush input.
- Synchronisers, edge detection, framing FSM and the deserialiser stay in the top module.

Test Plan:
All scenarios use SLOT_WIDTH=24, FIFO_DEPTH=4, BCLK = DATA_CLK/8, 32 BCLK per channel unless noted.
1. Enable mid-left-word, then send L=0xA5A5A5, R=0x5A5A5A -> the partial first word is dropped; outputs are TDATA=0xA5A5A5/TID=0, then 0x5A5A5A/TID=1; M_TREADY held at 1.
2. 16 BCLK per channel, L=0x1234, R=0xFFFF -> TDATA=0x123400 then 0xFFFF00.
3. M_TREADY=0 for 6 completed words (0x000001..0x000006) -> FIFO holds 1..4 and OVERRUN_O=1; raising M_TREADY then yields 1,2,3,4 in order and M_TVALID=0.
4. FIFO full, M_TREADY pulsed for one cycle exactly on a push cycle -> no overrun; FIFO holds 2..5.
5. ENABLE_I=0 mid-word with 2 entries queued -> the next cycle has M_TVALID=0 and OVERRUN_O=0; after re-enable, the first complete word arrives only after a boundary event.
6. RESETN low asynchronously mid-word -> all outputs 0 before the next DATA_CLK_I edge; after release the block is in IDLE.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S slave receiver.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN
  } rx_state_t;

  localparam logic CH_LEFT   = 1'b0;
  localparam logic CH_RIGHT  = 1'b1;
  localparam int   BIT_CNT_W = 6;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Small synchronous sample FIFO; a full FIFO still accepts a push when a pop
// happens in the same cycle.
module i2s_sample_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversamples BCLK/LRCLK/SDATA, deserialises each channel
// word MSB-first and streams channel-tagged samples out through a small FIFO.
module i2s_slave_rx
  import i2s_pkg::*;
#(
  parameter int SLOT_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  DATA_CLK_I,
  input  logic                  RESETN,
  input  logic                  ENABLE_I,
  input  logic                  BCLK_I,
  input  logic                  LRCLK_I,
  input  logic                  SDATA_I,
  output logic [SLOT_WIDTH-1:0] M_TDATA,
  output logic                  M_TID,
  output logic                  M_TVALID,
  input  logic                  M_TREADY,
  output logic                  OVERRUN_O
);

  logic [1:0]           bclk_sync;
  logic [1:0]           lr_sync;
  logic [1:0]           sd_sync;
  logic                 bclk_prev;
  logic                 bit_event;
  logic                 evt_lr;
  logic                 evt_sd;

  rx_state_t            state;
  logic                 lr_prev;
  logic                 lr_valid;
  logic [SLOT_WIDTH-1:0] shift_reg;
  logic [SLOT_WIDTH-1:0] shift_next;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 push_valid;
  logic [SLOT_WIDTH:0]  push_word;
  logic                 overrun;
  logic                 boundary;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [SLOT_WIDTH:0]  fifo_head;

  // The event and its LR/SD samples are registered together so they line up.
  always_ff @(posedge DATA_CLK_I or negedge RESETN) begin
    if (!RESETN) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      bclk_prev <= 1'b0;
      bit_event <= 1'b0;
      evt_lr    <= 1'b0;
      evt_sd    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], BCLK_I};
      lr_sync   <= {lr_sync[0], LRCLK_I};
      sd_sync   <= {sd_sync[0], SDATA_I};
      bclk_prev <= bclk_sync[1];
      bit_event <= bclk_sync[1] & ~bclk_prev;
      evt_lr    <= lr_sync[1];
      evt_sd    <= sd_sync[1];
    end
  end

  assign boundary = bit_event & lr_valid & (evt_lr != lr_prev);

  // Current bit placed at its MSB-first slot; bits past SLOT_WIDTH fall away.
  always_comb begin
    shift_next = shift_reg;
    for (int i = 0; i < SLOT_WIDTH; i++) begin
      if (int'(bit_cnt) == SLOT_WIDTH - 1 - i) begin
        shift_next[i] = evt_sd;
      end
    end
  end

  always_ff @(posedge DATA_CLK_I or negedge RESETN) begin
    if (!RESETN) begin
      state      <= IDLE;
      lr_prev    <= CH_LEFT;
      lr_valid   <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      push_valid <= 1'b0;
      push_word  <= '0;
      overrun    <= 1'b0;
    end else if (!ENABLE_I) begin
      state      <= IDLE;
      lr_valid   <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      push_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      push_valid <= 1'b0;
      if (push_valid && fifo_full && !fifo_pop) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: state <= SYNC;
        SYNC, RUN: begin
          if (bit_event) begin
            lr_prev  <= evt_lr;
            lr_valid <= 1'b1;
            if (boundary) begin
              // The boundary bit still belongs to the word that just ended.
              if (state == RUN) begin
                push_valid <= 1'b1;
                push_word  <= {(lr_prev ? CH_RIGHT : CH_LEFT), shift_next};
              end
              state     <= RUN;
              shift_reg <= '0;
              bit_cnt   <= '0;
            end else begin
              shift_reg <= shift_next;
              if (bit_cnt != {BIT_CNT_W{1'b1}}) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fifo_pop = ~fifo_empty & M_TREADY;

  i2s_sample_fifo #(
    .WIDTH (SLOT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (DATA_CLK_I),
    .rst_n     (RESETN),
    .flush     (~ENABLE_I),
    .push      (push_valid),
    .push_data (push_word),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign M_TDATA   = fifo_head[SLOT_WIDTH-1:0];
  assign M_TID     = fifo_head[SLOT_WIDTH];
  assign M_TVALID  = ~fifo_empty;
  assign OVERRUN_O = overrun;

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Scoreboard bench for i2s_slave_rx: drives an I2S stream with BCLK = DATA_CLK/8
// and compares every accepted output sample against queued expectations.
module tb_i2s_slave_rx;

  localparam logic L = 1'b0;
  localparam logic R = 1'b1;

  typedef struct packed {
    logic [23:0] data;
    logic        tid;
  } exp_t;

  typedef struct packed {
    logic ch;
    logic sd;
    logic pulse;
  } bit_t;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic [23:0] m_tdata;
  logic        m_tid;
  logic        m_tvalid;
  logic        tready_main;
  logic        tready_pulse;
  logic        m_tready;
  logic        overrun;

  exp_t        sb[$];
  bit_t        bitq[$];
  int          checks;
  int          passed;
  event        pulse_ev;

  assign m_tready = tready_main | tready_pulse;

  i2s_slave_rx #(
    .SLOT_WIDTH (24),
    .FIFO_DEPTH (4)
  ) dut (
    .DATA_CLK_I (clk),
    .RESETN     (rst_n),
    .ENABLE_I   (enable),
    .BCLK_I     (bclk),
    .LRCLK_I    (lrclk),
    .SDATA_I    (sdata),
    .M_TDATA    (m_tdata),
    .M_TID      (m_tid),
    .M_TVALID   (m_tvalid),
    .M_TREADY   (m_tready),
    .OVERRUN_O  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  // A word carries nbits bits taken MSB-first from val32; missing LSBs read as 0.
  task automatic expectWord(input logic ch, input logic [31:0] val32, input int nbits);
    logic [23:0] d;
    d = val32[31:8];
    if (nbits < 24) begin
      d = d & ~(24'hFFFFFF >> nbits);
    end
    sb.push_back('{data: d, tid: ch});
  endtask

  task automatic sendWord(input logic ch, input logic [31:0] val32, input int nbits,
                          input bit exp_en, input bit pulse_last);
    logic [31:0] v;
    v = val32;
    for (int i = 0; i < nbits; i++) begin
      bitq.push_back('{ch: ch, sd: v[31], pulse: (pulse_last && (i == nbits - 1))});
      v = v << 1;
    end
    if (exp_en) begin
      expectWord(ch, val32, nbits);
    end
  endtask

  task automatic driveBit(input logic lr, input logic sd, input logic pulse);
    @(negedge clk);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    repeat (3) @(negedge clk);
    @(negedge clk);
    bclk = 1'b1;
    if (pulse) -> pulse_ev;
    repeat (3) @(negedge clk);
  endtask

  // LRCLK leads the data by one bit: it shows the channel of the following bit.
  task automatic applyStimulus();
    logic lr;
    for (int k = 0; k < bitq.size(); k++) begin
      lr = (k + 1 < bitq.size()) ? bitq[k+1].ch : bitq[k].ch;
      driveBit(lr, bitq[k].sd, bitq[k].pulse);
    end
    bitq.delete();
  endtask

  task automatic restart();
    @(negedge clk);
    enable = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_tvalid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    #3;
    checkOutput({tag, "_sb_left"}, sb.size(), 0);
    checkOutput({tag, "_tvalid"}, m_tvalid, 0);
  endtask

  // One-cycle ready pulse aligned to the push cycle of the word ending at this bit.
  initial begin
    tready_pulse = 1'b0;
    forever begin
      @(pulse_ev);
      repeat (4) @(negedge clk);
      tready_pulse = 1'b1;
      @(negedge clk);
      tready_pulse = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (rst_n && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        checkOutput("tdata", m_tdata, e.data);
        checkOutput("tid", m_tid, e.tid);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks      = 0;
    passed      = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    bclk        = 1'b0;
    lrclk       = 1'b0;
    sdata       = 1'b0;
    tready_main = 1'b0;

    repeat (3) @(negedge clk);
    #3;
    checkOutput("rst_tdata", m_tdata, 0);
    checkOutput("rst_tid", m_tid, 0);
    checkOutput("rst_tvalid", m_tvalid, 0);
    checkOutput("rst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] scenario 1: partial word dropped, 24-bit L/R");
    @(negedge clk);
    enable      = 1'b1;
    tready_main = 1'b1;
    sendWord(R, 32'hDEADBEEF, 4, 0, 0);
    sendWord(L, {24'hA5A5A5, 8'h00}, 32, 1, 0);
    sendWord(R, {24'h5A5A5A, 8'h00}, 32, 1, 0);
    sendWord(L, 32'h0, 2, 0, 0);
    applyStimulus();
    waitDrain("s1");

    $display("[TB] scenario 2: 16-bit slots");
    restart();
    sendWord(R, 32'hFFFFFFFF, 4, 0, 0);
    sendWord(L, {16'h1234, 16'h0000}, 16, 1, 0);
    sendWord(R, {16'hFFFF, 16'hFFFF}, 16, 1, 0);
    sendWord(L, 32'h0, 2, 0, 0);
    applyStimulus();
    waitDrain("s2");

    $display("[TB] scenario 4: push and pop together while full");
    restart();
    tready_main = 1'b0;
    sendWord(R, 32'h0, 4, 0, 0);
    for (int w = 1; w <= 5; w++) begin
      sendWord((w % 2 == 1) ? L : R, {24'(w), 8'h00}, 32, 1, (w == 5));
    end
    sendWord(R, 32'h0, 2, 0, 0);
    applyStimulus();
    repeat (10) @(negedge clk);
    #3;
    checkOutput("s4_overrun", overrun, 0);
    checkOutput("s4_tvalid", m_tvalid, 1);
    checkOutput("s4_head", m_tdata, 2);
    @(negedge clk);
    tready_main = 1'b1;
    waitDrain("s4");

    $display("[TB] scenario 3: overflow with ready low");
    restart();
    tready_main = 1'b0;
    sendWord(R, 32'h0, 4, 0, 0);
    for (int w = 1; w <= 6; w++) begin
      sendWord((w % 2 == 1) ? L : R, {24'(w), 8'h00}, 32, (w <= 4), 0);
    end
    sendWord(L, 32'hC0000000, 2, 0, 0);
    applyStimulus();
    repeat (10) @(negedge clk);
    #3;
    checkOutput("s3_overrun", overrun, 1);
    checkOutput("s3_tvalid", m_tvalid, 1);
    checkOutput("s3_head", m_tdata, 1);
    @(negedge clk);
    tready_main = 1'b1;
    waitDrain("s3");
    checkOutput("s3_overrun_sticky", overrun, 1);

    $display("[TB] scenario 5: disable mid-word with entries queued");
    @(negedge clk);
    tready_main = 1'b0;
    expectWord(L, 32'hC0000000, 2);
    sendWord(R, {24'h0000BB, 8'h00}, 32, 1, 0);
    sendWord(L, 32'hFFFFFFFF, 10, 0, 0);
    applyStimulus();
    repeat (4) @(negedge clk);
    #3;
    checkOutput("s5_pre_tvalid", m_tvalid, 1);
    checkOutput("s5_pre_overrun", overrun, 1);
    @(negedge clk);
    enable = 1'b0;
    sb.delete();
    @(negedge clk);
    #3;
    checkOutput("s5_off_tvalid", m_tvalid, 0);
    checkOutput("s5_off_overrun", overrun, 0);
    @(negedge clk);
    enable      = 1'b1;
    tready_main = 1'b1;
    sendWord(L, 32'hFFFFFFFF, 10, 0, 0);
    sendWord(R, {24'hABCDEF, 8'h00}, 32, 1, 0);
    sendWord(L, 32'h0, 2, 0, 0);
    applyStimulus();
    waitDrain("s5");

    $display("[TB] scenario 6: asynchronous reset mid-word");
    restart();
    tready_main = 1'b0;
    sendWord(R, 32'h0, 4, 0, 0);
    sendWord(L, {24'h13579B, 8'h00}, 32, 1, 0);
    sendWord(R, 32'hFFFFFFFF, 10, 0, 0);
    applyStimulus();
    repeat (2) @(negedge clk);
    #3;
    checkOutput("s6_pre_tvalid", m_tvalid, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_tdata", m_tdata, 0);
    checkOutput("s6_rst_tid", m_tid, 0);
    checkOutput("s6_rst_tvalid", m_tvalid, 0);
    checkOutput("s6_rst_overrun", overrun, 0);
    sb.delete();
    @(negedge clk);
    rst_n       = 1'b1;
    tready_main = 1'b1;
    sendWord(R, 32'hFFFFFFFF, 5, 0, 0);
    sendWord(L, {24'h0F0F0F, 8'h00}, 32, 1, 0);
    sendWord(R, 32'h0, 2, 0, 0);
    applyStimulus();
    waitDrain("s6");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
